serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Bit-serial multi-bit adder built around the team's 1-bit `full_add` cell, which is instantiated once as the per-bit datapath.
- Loads two WIDTH-bit operands and a carry-in on a start request.
- Feeds one bit pair per clock, LSB first, into `full_add`, and registers `cout` back as the next carry.
- Presents the registered WIDTH-bit sum and final carry-out with a one-cycle done pulse.
- Sits between a command/register source and any consumer that needs low-area multi-bit addition.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on the accepting edge
- b_in  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress (SHIFT state)
- done  output  1  one-cycle completion pulse (DONE state)
- sum_out  output  WIDTH  registered sum of the last completed addition
- cout_out  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low; one clock domain (clk).
  - Reset value of every output is 0: busy, done, sum_out, cout_out.
  - Internal shift registers, carry register and bit counter also reset to 0; state resets to IDLE.
- Datapath:
  - `full_add` inputs: a = a_sr[0], b = b_sr[0], cin = carry_r.
  - Each SHIFT cycle:
    - a_sr and b_sr shift right by 1.
    - s_sr shifts right, with the `full_add` sum entering at bit WIDTH-1.
    - carry_r <= `full_add` cout.
  - Bit counter width is clog2(WIDTH). It counts 0..WIDTH-1 and does not wrap in normal operation.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: busy=0, done=0.
    - start=1 at edge E0: load a_sr<=a_in, b_sr<=b_in, carry_r<=cin, cnt<=0; go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1.
    - Process one bit per edge.
    - On the edge where cnt==WIDTH-1: sum_out <= final s_sr value (including this bit) and cout_out <= `full_add` cout; go to DONE.
    - Otherwise cnt<=cnt+1.
  - DONE: done=1, busy=0; unconditionally go to IDLE on the next edge.
- Latency and throughput:
  - done is high during the cycle following edge E_WIDTH, where E0 is the edge that accepted start.
  - sum_out and cout_out are valid from that same cycle.
  - Minimum spacing between accepted starts is WIDTH+2 edges.
- Handshake and boundaries:
  - start is ignored in SHIFT and DONE; no queuing, no error flag.
  - a_in, b_in and cin may change freely after E0 without affecting the operation in progress.
  - start held continuously high: a new operation is accepted on the first edge after DONE, i.e. back-to-back at the minimum spacing.
  - Output hold: sum_out and cout_out hold their values until the next completion. They are not cleared on start, so a consumer reads them only with or after done.
  - Overflow: WIDTH-bit sum wraps modulo 2^WIDTH; the overflow bit appears only on cout_out.
  - Reset mid-operation (rst_n low in any state): immediate return to IDLE with all outputs 0. The operation is lost and no done pulse is issued.
- Arithmetic result: {cout_out, sum_out} == a_in + b_in + cin, computed exactly at full WIDTH+1 precision.

Test Plan:
- WIDTH=8; a_in=0x5A, b_in=0x3C, cin=1, start pulse 1 cycle -> busy high 8 cycles; done high exactly 1 cycle at E8+; sum_out=0x97, cout_out=0.
- a_in=0xFF, b_in=0x01, cin=0 -> sum_out=0x00, cout_out=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum_out=0xFF, cout_out=1.
- Start accepted with 0x10+0x20; start re-pulsed with 0xAA+0x55 at cycles 3 and 9 (SHIFT/DONE) -> both ignored; single done with sum_out=0x30, cout_out=0; busy falls after 8 cycles.
- start held high with constant a_in=0x01, b_in=0x01, cin=0 -> done pulses every 10 cycles; sum_out=0x02 each time; no missed or extra pulses.
- rst_n asserted asynchronously mid-edge at cycle 4 of an operation -> busy, done, sum_out and cout_out go to 0 immediately; no done pulse; after release, a new 0x80+0x80 op gives sum_out=0x00, cout_out=1.
- Random: 1000 operations at WIDTH=8 and WIDTH=32 compared against the reference model a+b+cin -> zero mismatches; done count equals accepted start count.

Source files
------------

// File: rtl/serial_add.sv
// serial_add: bit-serial WIDTH-bit adder built on one full_add cell.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin an addition (sampled in IDLE only)
//   a_in, b_in, cin : operands and carry-in, captured on the accepting edge
//   busy            : high while bits are being processed
//   done            : one-cycle completion pulse
//   sum_out         : sum of the last completed addition (held)
//   cout_out        : carry-out of the last completed addition (held)
// One bit pair is added per clock, LSB first; the carry is fed back
// through a register.

// full_add: 1-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 sum bits produced so far; the MSB comes straight
  // from the adder on the last cycle, so no extra flop is needed for it.
  logic [WIDTH-2:0]   s_sr_q, s_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_sum_c;
  logic               fa_cout_c;
  logic [WIDTH-1:0]   s_next_c;

  // Per-bit datapath
  full_add u_full_add (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_c),
    .cout (fa_cout_c)
  );

  // Sum register after inserting the current bit at the top
  assign s_next_c = {fa_sum_c, s_sr_q};

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_next_c[WIDTH-1:1];
        carry_d = fa_cout_c;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = s_next_c;
          cout_d  = fa_cout_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the state being entered
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Testbench for serial_add (WIDTH=8): directed vectors with hand-computed
// results pushed into a scoreboard queue; a negedge monitor pops and
// compares on every done pulse.
module tb_serial_add;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  logic [W:0]   exp_q[$];
  int           total;
  int           bad;
  int           n_acc;
  int           n_done;

  serial_add #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W:0] e;
      n_done++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result: unexpected done, got cout=%0b sum=%02h, no result outstanding",
                 cout_out, sum_out);
      end else begin
        e = exp_q.pop_front();
        if ({cout_out, sum_out} !== e) begin
          bad++;
          $display("FAIL result: got cout=%0b sum=%02h, want cout=%0b sum=%02h",
                   cout_out, sum_out, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check_int({tag, "_sum"}, int'(sum_out), 0);
    check1({tag, "_cout"}, cout_out, 1'b0);
  endtask

  // One addition; expected {cout,sum} supplied by caller
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W:0] expv);
    int  busy_n;
    bit  seen;
    @(posedge clk); #1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    exp_q.push_back(expv);
    n_acc++;
    @(posedge clk); #1;
    start  = 1'b0;
    a_in   = ~a;
    b_in   = ~b;
    cin    = ~c;
    busy_n = busy ? 1 : 0;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    check1("done_seen", seen, 1'b1);
    check_int("busy_cycles", busy_n, int'(W));
    check1("busy_low_at_done", busy, 1'b0);
    @(posedge clk); #1;
    check1("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    n_acc  = 0;
    n_done = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;

    #2;
    check_zero_outputs("reset");
    #20;
    rst_n = 1'b1;

    // Directed arithmetic
    do_op(8'h5A, 8'h3C, 1'b1, 9'h097);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    do_op(8'h00, 8'h00, 1'b0, 9'h000);
    do_op(8'h80, 8'h7F, 1'b1, 9'h100);

    // start re-pulsed in SHIFT and DONE must be ignored
    @(posedge clk); #1;
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h030);
    n_acc++;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      start = (e == 2 || e == 8);
      if (start) begin
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
      end
      if (e == 7) check1("ign_busy_last", busy, 1'b1);
      if (e == 8) check1("ign_done", done, 1'b1);
      if (e == 8) check1("ign_busy_fall", busy, 1'b0);
      if (e == 10) check1("ign_idle_busy", busy, 1'b0);
    end
    start = 1'b0;

    // start held high: one acceptance every W+2 edges
    @(posedge clk); #1;
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(9'h002);
      n_acc++;
    end
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 20) start = 1'b0;
      check1($sformatf("held_done_e%0d", e), done,
             (e == 8 || e == 18 || e == 28));
    end
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    a_in = 8'h33; b_in = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check1("pre_reset_busy", busy, 1'b1);
    check_int("pre_reset_sum", int'(sum_out), 2);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      check1($sformatf("no_done_after_reset_%0d", e), done, 1'b0);
    end
    do_op(8'h80, 8'h80, 1'b0, 9'h100);

    // Pseudo-random operands against a+b+cin
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end

    repeat (5) @(posedge clk);
    #1;
    check_int("done_count", n_done, n_acc);
    check_int("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

endmodule
